// File: rtl/aoc_day1_pkg.sv
// Shared constants and state encoding for the rotation-line parser.
// The ASCII codes name the only characters the grammar cares about.
package aoc_day1_pkg;

  localparam int DEF_DATA_W = 32;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NUM  = 3'd1,
    ST_SKIP = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/dec_digit_acc.sv
// Combinational acc*10+digit with saturation to all-ones on overflow.
// Four extra bits hold the worst case (2^W-1)*10+9 < 16*2^W without wrap.
module dec_digit_acc #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [3:0]        digit_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              ovf_o
);

  logic [DATA_W+3:0] wide;

  always_comb begin
    wide  = ({4'b0000, acc_i} << 3) + ({4'b0000, acc_i} << 1)
          + {{DATA_W{1'b0}}, digit_i};
    ovf_o = |wide[DATA_W+3:DATA_W];
    acc_o = ovf_o ? {DATA_W{1'b1}} : wide[DATA_W-1:0];
  end

endmodule

// File: rtl/rotation_parser.sv
// Parses "R<digits>\n" / "L<digits>\n" lines into (dir, magnitude) records.
// Input:  in_valid/in_ready; output: out_valid/out_ready; a transfer happens only when both are high on a rising clk edge.
module rotation_parser
  import aoc_day1_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_dir_r,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  rec_count,
  output logic              err,
  output logic              ovf,
  output logic              done,
  output logic [2:0]        state_dbg
);

  state_t            state_q, state_d;
  logic              dir_q, ndig_q, last_seen_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              acc_ovf;
  logic              in_ready_q, out_valid_q, out_dir_r_q, err_q, ovf_q, done_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CNT_W-1:0]  rec_count_q;
  logic              in_fire, out_fire, is_digit, is_dir, is_ws, err_d;

  dec_digit_acc #(.DATA_W(DATA_W)) u_acc (
    .acc_i   (acc_q),
    .digit_i (in_data[3:0]),
    .acc_o   (acc_d),
    .ovf_o   (acc_ovf)
  );

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;
  assign is_digit = (in_data >= CH_0) && (in_data <= CH_9);
  assign is_dir   = (in_data == CH_R) || (in_data == CH_L);
  assign is_ws    = (in_data == CH_LF) || (in_data == CH_CR) || (in_data == CH_SP);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (in_fire) begin
        if (is_dir)     state_d = ST_NUM;
        else if (is_ws) state_d = ST_IDLE;
        else begin
          state_d = ST_SKIP;
          err_d   = 1'b1;
        end
        if (in_last) state_d = ST_DONE;
      end
      ST_NUM: if (in_fire) begin
        if (is_digit) begin
          state_d = in_last ? ST_HOLD : ST_NUM;
        end else if (in_data == CH_CR) begin
          // A trailing CR on the final byte still closes a line with digits.
          state_d = !in_last ? ST_NUM : (ndig_q ? ST_HOLD : ST_DONE);
          err_d   = in_last && !ndig_q;
        end else if (in_data == CH_LF) begin
          state_d = ndig_q ? ST_HOLD : (in_last ? ST_DONE : ST_IDLE);
          err_d   = !ndig_q;
        end else begin
          state_d = in_last ? ST_DONE : ST_SKIP;
          err_d   = 1'b1;
        end
      end
      ST_SKIP: if (in_fire) begin
        if (in_last)              state_d = ST_DONE;
        else if (in_data == CH_LF) state_d = ST_IDLE;
      end
      ST_HOLD: if (out_fire) state_d = last_seen_q ? ST_DONE : ST_IDLE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= 1'b0;
      ndig_q      <= 1'b0;
      last_seen_q <= 1'b0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_dir_r_q <= 1'b0;
      out_data_q  <= '0;
      rec_count_q <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_NUM) || (state_d == ST_SKIP);
      out_valid_q <= (state_d == ST_HOLD);
      done_q      <= (state_d == ST_DONE);
      if (err_d) err_q <= 1'b1;
      if (in_fire && in_last) last_seen_q <= 1'b1;
      if (state_q == ST_IDLE && in_fire && is_dir) begin
        dir_q  <= (in_data == CH_R);
        acc_q  <= '0;
        ndig_q <= 1'b0;
      end
      if (state_q == ST_NUM && in_fire && is_digit) begin
        acc_q  <= acc_d;
        ndig_q <= 1'b1;
        if (acc_ovf) ovf_q <= 1'b1;
      end
      // The record is frozen on HOLD entry so it stays stable while stalled.
      if (state_q == ST_NUM && state_d == ST_HOLD) begin
        out_dir_r_q <= dir_q;
        out_data_q  <= is_digit ? acc_d : acc_q;
      end
      if (out_fire) rec_count_q <= rec_count_q + CNT_W'(1);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_dir_r = out_dir_r_q;
  assign out_data  = out_data_q;
  assign rec_count = rec_count_q;
  assign err       = err_q;
  assign ovf       = ovf_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rotation_parser.sv
// Directed bench for rotation_parser: each task drives one scenario and
// checks its outputs against hand-computed values.
module tb_rotation_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_dir_r;
  logic [31:0] out_data;
  logic [15:0] rec_count;
  logic        err, ovf, done;
  logic [2:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  rotation_parser dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dir_r (out_dir_r),
    .out_data  (out_data),
    .rec_count (rec_count),
    .err       (err),
    .ovf       (ovf),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Records captured at the negedge preceding the handshake edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) got_q.push_back({out_dir_r, out_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Presents one byte and returns #1 after the edge on which it was accepted.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout byte %h in_ready got %b want 1", b, in_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic send_str(input string s, input logic last_on_end);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_on_end && (i == s.len() - 1));
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({in_ready, out_valid, out_dir_r, err, ovf, done} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 100000", {in_ready, out_valid, out_dir_r, err, ovf, done});
    end
    vectors++;
    if (out_data !== 32'd0 || rec_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_data got data=%0d cnt=%0d want 0 0", out_data, rec_count);
    end
  endtask

  task automatic test_r48();
    do_reset();
    send_str("R48", 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL r48_early_valid got %b want 0", out_valid);
    end
    send_byte(8'h0A, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_dir_r !== 1'b1 || out_data !== 32'd48) begin
      miscompares++;
      $display("FAIL r48_record got v=%b d=%b data=%0d want 1 1 48", out_valid, out_dir_r, out_data);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || rec_count !== 16'd1) begin
      miscompares++;
      $display("FAIL r48_after got v=%b cnt=%0d want 0 1", out_valid, rec_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    send_str("L68\r\n", 1'b0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_dir_r !== 1'b0 || out_data !== 32'd68 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold cyc %0d got v=%b d=%b data=%0d rdy=%b want 1 0 68 0",
                 i, out_valid, out_dir_r, out_data, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || rec_count !== 16'd1) begin
      miscompares++;
      $display("FAIL stall_release got v=%b cnt=%0d want 0 1", out_valid, rec_count);
    end
    send_str("L30\n", 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_dir_r !== 1'b0 || out_data !== 32'd30) begin
      miscompares++;
      $display("FAIL stall_l30 got v=%b d=%b data=%0d want 1 0 30", out_valid, out_dir_r, out_data);
    end
    @(posedge clk); #1;
    vectors++;
    if (rec_count !== 16'd2 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_count got cnt=%0d err=%b want 2 0", rec_count, err);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    send_str("R4294967295\n", 1'b0);
    vectors++;
    if (out_data !== 32'hFFFF_FFFF || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_max got data=%h ovf=%b want ffffffff 0", out_data, ovf);
    end
    @(posedge clk); #1;
    send_str("R429496729", 1'b0);
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_pre got ovf=%b want 0", ovf);
    end
    send_str("6\n", 1'b0);
    vectors++;
    if (out_data !== 32'hFFFF_FFFF || ovf !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_over got data=%h ovf=%b err=%b want ffffffff 1 0", out_data, ovf, err);
    end
    @(posedge clk); #1;
    send_str("L12\n", 1'b0);
    vectors++;
    if (out_data !== 32'd12 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_sticky got data=%0d ovf=%b want 12 1", out_data, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_line();
    do_reset();
    got_q.delete();
    send_byte("X", 1'b0);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_err got %b want 1", err);
    end
    send_str("12\nL5\n", 1'b0);
    @(posedge clk); #1;
    send_str("R\n", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (got_q.size() != 1 || rec_count !== 16'd1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_count got recs=%0d cnt=%0d err=%b want 1 1 1", got_q.size(), rec_count, err);
    end
    vectors++;
    if (got_q.size() < 1 || got_q[0] !== {1'b0, 32'd5}) begin
      miscompares++;
      $display("FAIL bad_record got %h want %h", (got_q.size() > 0) ? got_q[0] : 33'h0, {1'b0, 32'd5});
    end
  endtask

  task automatic test_last();
    do_reset();
    send_byte("L", 1'b0);
    send_byte("0", 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_dir_r !== 1'b0 || out_data !== 32'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL last_record got v=%b d=%b data=%0d done=%b want 1 0 0 0",
               out_valid, out_dir_r, out_data, done);
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = "R";
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (done !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || rec_count !== 16'd1) begin
        miscompares++;
        $display("FAIL last_done cyc %0d got done=%b rdy=%b v=%b cnt=%0d want 1 0 0 1",
                 i, done, in_ready, out_valid, rec_count);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    out_ready = 1'b0;
    send_str("R7\n", 1'b0);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rhold_pre got v=%b want 1", out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || rec_count !== 16'd0 || out_data !== 32'd0) begin
      miscompares++;
      $display("FAIL rhold_drop got v=%b cnt=%0d data=%0d want 0 0 0", out_valid, rec_count, out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rhold_ready got %b want 1", in_ready);
    end
    send_str("R1\n", 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_dir_r !== 1'b1 || out_data !== 32'd1) begin
      miscompares++;
      $display("FAIL rhold_r1 got v=%b d=%b data=%0d want 1 1 1", out_valid, out_dir_r, out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({1'b1, 32'd1});
    exp_q.push_back({1'b0, 32'd23});
    exp_q.push_back({1'b1, 32'd456});
    send_str(" R1\nL23\r\n\nR456", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (got_q.size() != exp_q.size() || done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_count got recs=%0d done=%b want %0d 1", got_q.size(), done, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_rec %0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 33'h0, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r48();
    test_stall();
    test_saturate();
    test_bad_line();
    test_last();
    test_reset_in_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rotation_parser.md
ROTATION_PARSER -- requirements
Module: rotation_parser

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the parsed rotation magnitude.
REQ-002 SHALL have parameter CNT_W, default 16, width of the emitted-record counter.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port in_valid  input  1  byte on in_data valid.
REQ-006 SHALL have port in_ready  output  1  byte accepted when in_valid&&in_ready.
REQ-007 SHALL have port in_data  input  8  ASCII byte of the puzzle text.
REQ-008 SHALL have port in_last  input  1  qualifies final byte of the stream.
REQ-009 SHALL have port out_valid  output  1  parsed record available.
REQ-010 SHALL have port out_ready  input  1  downstream dial counter takes record.
REQ-011 SHALL have port out_dir_r  output  1  1 = 'R' (add), 0 = 'L' (subtract).
REQ-012 SHALL have port out_data  output  DATA_W  rotation magnitude.
REQ-013 SHALL have port rec_count  output  CNT_W  records handed off, wraps mod 2^CNT_W.
REQ-014 SHALL have ports err, ovf, done  output  1 each  sticky malformed-input, sticky magnitude-saturation, stream complete.

Function
REQ-015 SHALL implement states IDLE, NUM, SKIP, HOLD, DONE.
REQ-016 SHALL drive in_ready=1 in IDLE/NUM/SKIP and 0 in HOLD/DONE.
REQ-017 IDLE: 'R' -> dir=1, acc=0, ndig=0, NUM; 'L' -> dir=0, same; '\n','\r',' ' ignored; any other byte -> err=1, SKIP.
REQ-018 NUM: '0'..'9' -> acc = acc*10 + digit, ndig++; '\r' ignored; '\n' -> HOLD if ndig>0, else err=1 and IDLE; any other byte -> err=1, SKIP.
REQ-019 SKIP: discard bytes until '\n', then IDLE; no record emitted for the bad line.
REQ-020 Accumulation SHALL use a DATA_W+4-bit intermediate; result > 2^DATA_W-1 SHALL saturate acc to all-ones and set ovf; saturation persists for remaining digits of that line.
REQ-021 HOLD: out_valid=1; out_dir_r/out_data SHALL remain stable until out_valid&&out_ready; on handshake rec_count++ and go IDLE, or DONE if last_seen.
REQ-022 out_valid SHALL assert the cycle after the terminating byte is accepted (1-cycle latency); outputs registered.
REQ-023 in_last on an accepted byte SHALL set last_seen; in NUM with ndig>0 (including the final digit itself) SHALL go HOLD; in IDLE/SKIP, or NUM with ndig=0 (err=1), SHALL go DONE.
REQ-024 DONE: done=1, in_ready=0, out_valid=0; state SHALL be held until reset.
REQ-025 Bytes with in_valid=0 SHALL not alter state; in_data SHALL be ignored when not accepted.
REQ-026 err/ovf SHALL never clear except by reset.

Reset
REQ-027 On rst=0 (asynchronous): state=IDLE, out_valid=0, out_dir_r=0, out_data=0, rec_count=0, err=0, ovf=0, done=0, last_seen=0, acc=0, ndig=0.
REQ-028 Reset asserted mid-HOLD SHALL drop out_valid immediately, with no handshake completed; the pending record SHALL be lost.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-030 Shared package aoc_day1_pkg SHALL hold ASCII constants (CH_L, CH_R, CH_LF, CH_CR, CH_SP, CH_0, CH_9), state encoding, and DATA_W default.
REQ-031 One sub-module dec_digit_acc SHALL implement combinational saturating acc*10+digit with overflow flag.

Verification
REQ-032 "R48\n", out_ready=1 -> one record dir=1 data=48, out_valid high exactly one cycle after '\n' accept, rec_count=1.
REQ-033 "L68\r\nL30\n", out_ready=0 for 5 cycles -> L68 held stable, in_ready=0 while held; then L30; rec_count=2, err=0.
REQ-034 "R4294967296\n" -> data=0xFFFFFFFF, ovf=1, err=0.
REQ-035 "X12\nL5\n" -> err=1, single record dir=0 data=5.
REQ-036 "L0" with in_last on '0' -> record dir=0 data=0, then done=1, in_ready=0 permanently.
REQ-037 rst pulsed low while in HOLD with out_ready=0 -> out_valid=0 same cycle, rec_count=0, next "R1\n" parses to dir=1 data=1.
